// File: rtl/rom_nco_pkg.sv
// Shared types and elaboration-time helpers for the quarter-wave ROM NCO.
// They cover the quadrant type, the ROM entry generator and the reset tuning word.
package rom_nco_pkg;

    typedef logic [1:0] quadrant_t;

    localparam real PI = 3.14159265358979323846;

    // Entry idx of the quarter-wave table: truncated sin(idx*pi/(2*2**la)) scaled to peak.
    function automatic int quarter_sin_entry(int idx, int dw, int la);
        real peak;
        real angle;
        peak  = real'((1 << (dw - 1)) - 1);
        angle = real'(idx) * PI / (2.0 * real'(1 << la));
        return $rtoi($sin(angle) * peak);
    endfunction

    // round(2**pw * out/in); the real-to-integer cast rounds to nearest.
    function automatic logic [63:0] default_ftw(int pw, real in_mhz, real out_mhz);
        real ratio;
        ratio = (2.0 ** pw) * out_mhz / in_mhz;
        return 64'(longint'(ratio));
    endfunction

endpackage

// File: rtl/rom_quarter_sin_lut.sv
// Dual-read, registered quarter-wave sine ROM.
// The table is built at elaboration and shared by the sine and cosine channels.
module rom_quarter_sin_lut
    import rom_nco_pkg::*;
#(
    parameter int DW = 16,
    parameter int LA = 10
) (
    input  logic          clk,
    input  logic [LA-1:0] addr_a_i,
    input  logic [LA-1:0] addr_b_i,
    output logic [DW-2:0] data_a_o,
    output logic [DW-2:0] data_b_o
);

    localparam int DEPTH = 1 << LA;

    logic [DW-2:0] rom_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int ENTRY = quarter_sin_entry(i, DW, LA);
        assign rom_w[i] = (DW - 1)'(ENTRY);
    end

    // NOTE: ROM read registers carry no reset; validity is tracked by the pipeline tags.
    always_ff @(posedge clk) begin
        data_a_o <= rom_w[addr_a_i];
        data_b_o <= rom_w[addr_b_i];
    end

endmodule

// File: rtl/rom_nco_quadrature.sv
// Phase-accumulator NCO with runtime FTW, phase offset and sync.
// It produces quadrature sin/cos from one quarter-wave ROM with a fixed 3-cycle latency.
module rom_nco_quadrature
    import rom_nco_pkg::*;
#(
    parameter int  INT_DATA_WIDTH     = 16,
    parameter int  INT_PHASE_WIDTH    = 32,
    parameter int  INT_LUT_ADDR_WIDTH = 10,
    parameter real REAL_IN_FREQ_MHZ   = 125.0,
    parameter real REAL_OUT_FREQ_MHZ  = 25.0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    input  logic                              i_ftw_load,
    input  logic [INT_PHASE_WIDTH-1:0]        i_ftw,
    input  logic [INT_PHASE_WIDTH-1:0]        i_phase_offset,
    input  logic                              i_sync,
    output logic                              o_valid,
    output logic signed [INT_DATA_WIDTH-1:0]  o_sin,
    output logic signed [INT_DATA_WIDTH-1:0]  o_cos,
    output logic                              o_wrap
);

    localparam int DW = INT_DATA_WIDTH;
    localparam int PW = INT_PHASE_WIDTH;
    localparam int LA = INT_LUT_ADDR_WIDTH;

    localparam logic [PW-1:0]        DEFAULT_FTW = PW'(default_ftw(PW, REAL_IN_FREQ_MHZ, REAL_OUT_FREQ_MHZ));
    localparam logic signed [DW-1:0] PEAK        = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [LA:0]          QUARTER     = {1'b1, {LA{1'b0}}};

    function automatic logic [LA:0] fold_idx(quadrant_t q, logic [LA-1:0] k);
        return q[0] ? QUARTER - {1'b0, k} : {1'b0, k};
    endfunction

    logic [PW-1:0] ftw_q, acc_q, acc_d, acc_base, phase;
    logic [PW:0]   step_sum;
    logic          phase_lo_unused;

    logic          s1_valid_q, s1_wrap_q;
    quadrant_t     s1_quad_q;
    logic [LA-1:0] s1_k_q;

    quadrant_t     cos_quad;
    logic [LA:0]   sin_idx, cos_idx;

    logic          s2_valid_q, s2_wrap_q;
    logic          s2_sin_peak_q, s2_sin_neg_q, s2_cos_peak_q, s2_cos_neg_q;
    logic [DW-2:0] rom_sin, rom_cos;

    logic signed [DW-1:0] sin_mag, cos_mag, sin_d, cos_d;

    // Stage 0: a sync on a valid sample treats the accumulator as zero for that sample.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        acc_base = i_sync ? '0 : acc_q;
        phase    = acc_base + i_phase_offset;
        step_sum = {1'b0, acc_base} + {1'b0, ftw_q};
        acc_d    = acc_q;
        if (i_valid) begin
            acc_d = step_sum[PW-1:0];
        end else if (i_sync) begin
            acc_d = '0;
        end
    end

    assign phase_lo_unused = ^phase[PW-LA-3:0];

    always_comb begin
        cos_quad = s1_quad_q + 2'd1;
        sin_idx  = fold_idx(s1_quad_q, s1_k_q);
        cos_idx  = fold_idx(cos_quad, s1_k_q);
    end

    rom_quarter_sin_lut #(
        .DW (DW),
        .LA (LA)
    ) u_lut (
        .clk      (clk),
        .addr_a_i (sin_idx[LA-1:0]),
        .addr_b_i (cos_idx[LA-1:0]),
        .data_a_o (rom_sin),
        .data_b_o (rom_cos)
    );

    always_comb begin
        sin_mag = s2_sin_peak_q ? PEAK : signed'({1'b0, rom_sin});
        cos_mag = s2_cos_peak_q ? PEAK : signed'({1'b0, rom_cos});
        sin_d   = s2_sin_neg_q ? -sin_mag : sin_mag;
        cos_d   = s2_cos_neg_q ? -cos_mag : cos_mag;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_q         <= DEFAULT_FTW;
            acc_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_wrap_q     <= 1'b0;
            s1_quad_q     <= '0;
            s1_k_q        <= '0;
            s2_valid_q    <= 1'b0;
            s2_wrap_q     <= 1'b0;
            s2_sin_peak_q <= 1'b0;
            s2_sin_neg_q  <= 1'b0;
            s2_cos_peak_q <= 1'b0;
            s2_cos_neg_q  <= 1'b0;
            o_valid       <= 1'b0;
            o_wrap        <= 1'b0;
            o_sin         <= '0;
            o_cos         <= '0;
        end else begin
            if (i_ftw_load) begin
                ftw_q <= i_ftw;
            end
            acc_q         <= acc_d;
            s1_valid_q    <= i_valid;
            s1_wrap_q     <= step_sum[PW];
            s1_quad_q     <= phase[PW-1 -: 2];
            s1_k_q        <= phase[PW-3 -: LA];
            s2_valid_q    <= s1_valid_q;
            s2_wrap_q     <= s1_wrap_q;
            s2_sin_peak_q <= sin_idx[LA];
            s2_sin_neg_q  <= s1_quad_q[1];
            s2_cos_peak_q <= cos_idx[LA];
            s2_cos_neg_q  <= cos_quad[1];
            o_valid       <= s2_valid_q;
            o_wrap        <= s2_valid_q & s2_wrap_q;
            // Outputs hold their last sample across bubbles.
            if (s2_valid_q) begin
                o_sin <= sin_d;
                o_cos <= cos_d;
            end
        end
    end

endmodule

// File: tb/tb_rom_nco_quadrature.sv
// Scoreboard bench for rom_nco_quadrature: a phase-level reference model queues expected
// samples at issue time, and a negedge monitor checks them when o_valid appears.
module tb_rom_nco_quadrature;

    localparam int          PW      = 32;
    localparam int          LA      = 10;
    localparam int          PEAK    = 32767;
    localparam logic [31:0] DEF_FTW = 32'd858993459;
    localparam real         PI      = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_ftw_load = 1'b0;
    logic [31:0]        i_ftw = '0;
    logic [31:0]        i_phase_offset = '0;
    logic               i_sync = 1'b0;
    logic               o_valid, o_wrap;
    logic signed [15:0] o_sin, o_cos;

    always #5 clk = ~clk;

    rom_nco_quadrature dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_ftw_load     (i_ftw_load),
        .i_ftw          (i_ftw),
        .i_phase_offset (i_phase_offset),
        .i_sync         (i_sync),
        .o_valid        (o_valid),
        .o_sin          (o_sin),
        .o_cos          (o_cos),
        .o_wrap         (o_wrap)
    );

    typedef struct {
        int due;
        int sin_v;
        int cos_v;
        int wrap;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rst_sampled = 1'b0;
    int          hold_sin = 0;
    int          hold_cos = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_ftw = DEF_FTW;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_sampled <= rst;
    end

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Amplitude at a phase: the 12-bit full-wave angle index, shifted by quarter turns,
    // reflected into the first quadrant of the truncated table, with sign from the half-wave.
    function automatic int ref_wave(logic [31:0] phase, int quarter_turns);
        int n, q, k, m, mag;
        n = (int'(phase >> (PW - LA - 2)) + quarter_turns * 1024) % 4096;
        q = n / 1024;
        k = n % 1024;
        m = (q % 2 == 1) ? 1024 - k : k;
        mag = (m == 1024) ? PEAK : $rtoi($sin(real'(m) * PI / 2048.0) * real'(PEAK));
        return (q >= 2) ? -mag : mag;
    endfunction

    task automatic model_step(bit v, bit ld, logic [31:0] ftw, logic [31:0] off, bit sy, bit r);
        logic [31:0] base, phase;
        exp_t        e;
        if (r) begin
            m_acc = '0;
            m_ftw = DEF_FTW;
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
            return;
        end
        if (v) begin
            base    = sy ? 32'd0 : m_acc;
            phase   = base + off;
            e.due   = cyc + 3;
            e.sin_v = ref_wave(phase, 0);
            e.cos_v = ref_wave(phase, 1);
            e.wrap  = ((longint'(base) + longint'(m_ftw)) >= 64'h1_0000_0000) ? 1 : 0;
            m_acc   = base + m_ftw;
            sb.push_back(e);
        end else if (sy) begin
            m_acc = '0;
        end
        if (ld) m_ftw = ftw;
    endtask

    task automatic drive(bit v, bit ld, logic [31:0] ftw, logic [31:0] off, bit sy, bit r);
        @(posedge clk);
        #1;
        rst            = r;
        i_valid        = v;
        i_ftw_load     = ld;
        i_ftw          = ftw;
        i_phase_offset = off;
        i_sync         = sy;
        model_step(v, ld, ftw, off, sy, r);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_sampled) begin
                check("rst_valid", o_valid, 0);
                check("rst_sin", o_sin, 0);
                check("rst_cos", o_cos, 0);
                check("rst_wrap", o_wrap, 0);
                hold_sin = 0;
                hold_cos = 0;
            end else if (o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", o_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    check("sin", o_sin, e.sin_v);
                    check("cos", o_cos, e.cos_v);
                    check("wrap", o_wrap, e.wrap);
                    hold_sin = e.sin_v;
                    hold_cos = e.cos_v;
                end
            end else begin
                check("hold_sin", o_sin, hold_sin);
                check("hold_cos", o_cos, hold_cos);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_valid", o_valid, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit          v, ld, sy, r;
        logic [31:0] ftw, off;

        repeat (3) drive(0, 0, 0, 0, 0, 1);

        // Default tone straight out of reset.
        repeat (12) drive(1, 0, 0, 0, 0, 0);

        // Quarter-turn steps from a synced start; load shares a cycle with a valid sample.
        drive(1, 1, 32'h4000_0000, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        repeat (12) drive(1, 0, 0, 0, 0, 0);

        // 180 degree offset, then back to zero offset.
        repeat (8) drive(1, 0, 0, 32'h8000_0000, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);

        // Gapped valid pattern after a sync without a sample.
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
        end

        // Reset with samples in flight, then resume on the default FTW.
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1);
        repeat (6) drive(1, 0, 0, 0, 0, 0);

        // Zero FTW with a 45 degree offset.
        drive(0, 1, 32'd0, 0, 0, 0);
        drive(1, 0, 0, 32'h2000_0000, 1, 0);
        repeat (8) drive(1, 0, 0, 32'h2000_0000, 0, 0);

        // Randomised traffic.
        repeat (400) begin
            v   = ($urandom_range(0, 9) < 7);
            ld  = ($urandom_range(0, 19) == 0);
            ftw = $urandom;
            off = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            sy  = ($urandom_range(0, 29) == 0);
            r   = ($urandom_range(0, 99) == 0);
            drive(v, ld, ftw, off, sy, r);
        end

        repeat (6) drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
